// File: rtl/security_pkg.sv
// Shared types and constants for the security/fault-handling blocks.
// No logic; no latency.
// No flow control.
package security_pkg;

    typedef enum logic [1:0] {
        FH_IDLE   = 2'd0,
        FH_REPORT = 2'd1,
        FH_DRAIN  = 2'd2
    } nx_fh_state_e;

    typedef enum logic [1:0] {
        PRIV_U    = 2'd0,
        PRIV_S    = 2'd1,
        PRIV_RSVD = 2'd2,
        PRIV_M    = 2'd3
    } priv_e;

    // Instruction page fault: NX violations are reported with this cause.
    localparam logic [5:0] CAUSE_INSTR_PAGE_FAULT = 6'd12;

endpackage

// File: rtl/nx_fault_handler_sat_counter.sv
// Generic saturating event counter; clear has priority over increment.
// Latency: count updates one cycle after inc_i/clr_i.
// Backpressure: none, holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/nx_fault_handler.sv
// Captures NX fetch faults and presents them as a trap request; stalls fetch until redirect.
// Latency: fault_i in cycle N gives trap_valid_o/fetch_stall_o in N+1; min trap spacing 3 cycles.
// Backpressure: holds the request until trap_ready_i or flush_i; faults arriving while busy are dropped.
module nx_fault_handler
    import security_pkg::*;
#(
    parameter int          VA_WIDTH  = 64,
    parameter int          CNT_WIDTH = 16,
    parameter logic [5:0]  NX_CAUSE  = CAUSE_INSTR_PAGE_FAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fault_i,
    input  logic [VA_WIDTH-1:0]  fetch_pc_i,
    input  logic [1:0]           fetch_priv_i,
    input  logic                 flush_i,
    input  logic                 trap_ready_i,
    output logic                 trap_valid_o,
    output logic [VA_WIDTH-1:0]  trap_pc_o,
    output logic [1:0]           trap_priv_o,
    output logic [5:0]           trap_cause_o,
    output logic                 fetch_stall_o,
    input  logic                 clr_stats_i,
    output logic [CNT_WIDTH-1:0] fault_cnt_o,
    output logic                 dropped_o
);

    nx_fh_state_e        state_q, state_d;
    logic                capture_en;
    logic                drop_ev;
    logic                trap_accept;
    logic [VA_WIDTH-1:0] pc_q;
    priv_e               priv_q;
    logic                stall_q;
    logic                dropped_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        capture_en  = 1'b0;
        drop_ev     = 1'b0;
        trap_accept = 1'b0;
        case (state_q)
            FH_IDLE: begin
                if (fault_i && !flush_i) begin
                    capture_en = 1'b1;
                    state_d    = FH_REPORT;
                end
            end
            FH_REPORT: begin
                drop_ev = fault_i;
                // A redirect squashes the trap even if the trap unit is ready.
                if (flush_i) begin
                    state_d = FH_IDLE;
                end else if (trap_ready_i) begin
                    trap_accept = 1'b1;
                    state_d     = FH_DRAIN;
                end
            end
            FH_DRAIN: begin
                drop_ev = fault_i;
                if (flush_i) begin
                    state_d = FH_IDLE;
                end
            end
            default: state_d = FH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= '0;
            priv_q    <= PRIV_U;
            stall_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            if (capture_en) begin
                pc_q   <= fetch_pc_i;
                priv_q <= priv_e'(fetch_priv_i);
            end
            // Stall is a flop so fetch sees no combinational path from our inputs.
            stall_q <= (state_d != FH_IDLE);
            if (clr_stats_i) begin
                dropped_q <= 1'b0;
            end else if (drop_ev) begin
                dropped_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_fault_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_stats_i),
        .inc_i (trap_accept),
        .cnt_o (fault_cnt_o)
    );

    assign trap_valid_o  = (state_q == FH_REPORT) && !flush_i;
    assign trap_pc_o     = pc_q;
    assign trap_priv_o   = priv_q;
    assign trap_cause_o  = NX_CAUSE;
    assign fetch_stall_o = stall_q;
    assign dropped_o     = dropped_q;

endmodule

// File: doc/nx_fault_handler.md
Name: nx_fault_handler

Overview:
- Sequential stage directly downstream of the No-Execute checker.
- Captures each NX fetch fault together with the faulting PC and privilege level.
- Presents the fault as a valid/ready trap request to the trap/commit unit.
- Stalls fetch until the front-end is redirected, and keeps a saturating fault counter and a sticky dropped-fault flag for debug/perf readout.

Parameters:
- VA_WIDTH, 64, width of the fetch virtual address.
- CNT_WIDTH, 16, width of the saturating fault counter.
- NX_CAUSE, 6'd12, exception cause code driven with every NX trap (instruction page fault).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- fault_i  in  1  NX fault from the checker, valid for a single cycle per faulting fetch.
- fetch_pc_i  in  VA_WIDTH  PC of the fetch that produced fault_i.
- fetch_priv_i  in  2  privilege level of that fetch.
- flush_i  in  1  pipeline flush/redirect from the back-end.
- trap_ready_i  in  1  trap unit accepts the request.
- trap_valid_o  out  1  trap request pending.
- trap_pc_o  out  VA_WIDTH  captured faulting PC (becomes tval).
- trap_priv_o  out  2  captured privilege.
- trap_cause_o  out  6  equals NX_CAUSE.
- fetch_stall_o  out  1  hold the fetch unit.
- clr_stats_i  in  1  clear the counter and the dropped flag.
- fault_cnt_o  out  CNT_WIDTH  number of accepted NX traps.
- dropped_o  out  1  sticky flag: a fault arrived while the block was busy.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE; trap_valid_o, fetch_stall_o, dropped_o = 0; trap_pc_o, trap_priv_o, fault_cnt_o = 0. Reset asserted mid-operation abandons any pending trap with no handshake.
- FSM states: IDLE, REPORT, DRAIN.
- IDLE:
  - fault_i=1 and flush_i=0: capture fetch_pc_i/fetch_priv_i and go to REPORT.
  - fault_i=1 and flush_i=1: fault squashed, stay in IDLE, nothing captured.
- REPORT:
  - trap_valid_o = (state==REPORT) & ~flush_i, i.e. combinationally suppressed during a flush.
  - flush_i=1: go to IDLE, no trap delivered, counter unchanged; flush wins over a simultaneous trap_ready_i.
  - trap_ready_i=1 and flush_i=0: handshake completes, go to DRAIN, counter increments.
  - Captured fields are stable throughout REPORT.
- DRAIN: waits for the front-end redirect; flush_i=1 returns to IDLE.
- fetch_stall_o = 1 in REPORT or DRAIN, registered from the state (no combinational path from the inputs).
- Latency: fault_i in cycle N gives trap_valid_o and fetch_stall_o in cycle N+1. Minimum back-to-back trap spacing is 3 cycles (REPORT, DRAIN, IDLE).
- fault_i outside IDLE: ignored and sets dropped_o. Captured fields are not overwritten.
- Counter: increments by 1 per accepted trap and saturates at all-ones (no wrap).
- clr_stats_i: zeroes fault_cnt_o and dropped_o next cycle. A clear wins over a same-cycle increment or drop event.
- trap_cause_o is constant NX_CAUSE, independent of state.

Decomposition:
- Shared package security_pkg holds:
  - the state enum type nx_fh_state_e;
  - the cause constant CAUSE_INSTR_PAGE_FAULT (default source for NX_CAUSE);
  - the privilege encoding typedef priv_e.
- One natural sub-module: sat_counter, a generic saturating counter with inc/clr inputs and clear priority, reusable by other security perf counters.
- FSM and capture registers stay in nx_fault_handler.

Test Plan:
- Basic handshake: reset, then fault_i=1 with pc=0x4000_1000 and priv=0. Expect trap_valid_o=1 next cycle, trap_pc_o=0x4000_1000, fetch_stall_o=1. Hold trap_ready_i=0 for 3 cycles and confirm outputs stay stable. Pulse ready: fault_cnt_o=1, state DRAIN. Pulse flush_i: fetch_stall_o=0.
- Flush races: fault_i and flush_i in the same cycle gives no trap and no stall. In REPORT, flush_i=1 with trap_ready_i=1 gives trap_valid_o=0 that cycle, count unchanged, return to IDLE.
- Dropped faults: a second fault_i with pc=0x8000 while in REPORT keeps trap_pc_o at the first PC and sets dropped_o=1. clr_stats_i then clears dropped_o and fault_cnt_o to 0.
- Saturation: with CNT_WIDTH=4, complete 17 traps and expect fault_cnt_o=4'hF. clr_stats_i in the same cycle as a handshake yields 0.
- Reset mid-operation: assert rst_i during REPORT. Next cycle expect all outputs 0 and state IDLE. A fault after reset is reported normally.
- Back-to-back: faults issued every cycle give traps spaced exactly 3 cycles apart, with all intermediate faults flagged by dropped_o.
